// File: rtl/gcd_coproc.sv
// gcd_coproc: GCD coprocessor mapped onto the 16-bit CPU bus.
// Offers a subtractive (Euclid) mode and a binary (Stein) mode, plus zero-operand
// handling, abort, a saturating step counter and a one-cycle done interrupt.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   clk_en          lets the FSM advance; bus accesses ignore it
//   saddress        bus address; registers sit at BASE+0x00..0x14, 4-byte stride
//   srd, swr        read and write strobes
//   sdata_in        write data
//   sdata_out       combinational read data (0 unless srd hits a register)
//   done_irq        one-cycle pulse when a computation finishes
//   busy            high while the engine is running (STATUS.busy)
module gcd_coproc #(
    parameter int          WIDTH  = 32,
    parameter int          ITER_W = 16,
    parameter logic [15:0] BASE   = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic        done_irq,
    output logic        busy
);
    localparam int K_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SHIFT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a1, r_a2, r_a, r_b, r_result;
    logic [ITER_W-1:0] r_iter;
    logic [K_W-1:0]    r_k;
    logic              r_mode, r_pending, r_done, r_err, r_irq;

    logic w_wr_a1, w_wr_a2, w_wr_ctrl;
    logic w_abort, w_launch, w_start, w_zero, w_finish;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        if (&v)
            return v;
        return v + 1'b1;
    endfunction

    assign w_wr_a1   = swr && (saddress == BASE);
    assign w_wr_a2   = swr && (saddress == BASE + 16'h0004);
    assign w_wr_ctrl = swr && (saddress == BASE + 16'h0008);

    // Abort only matters while running and bypasses clk_en.
    assign w_abort  = w_wr_ctrl && sdata_in[2] && (r_state != S_IDLE);
    assign w_launch = clk_en && (r_state == S_IDLE) && r_pending;
    // A start arriving on the launch edge would immediately re-arm the engine,
    // so it is treated like a start while busy. Abort in the same write wins.
    assign w_start  = w_wr_ctrl && sdata_in[0] && !sdata_in[2]
                      && (r_state == S_IDLE) && !w_launch;
    assign w_zero   = (r_a1 == '0) || (r_a2 == '0);

    assign busy     = (r_state != S_IDLE);
    assign done_irq = r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        if (w_zero)
                            w_finish = 1'b1;
                        else
                            w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_a == r_b) begin
                        if (r_mode) begin
                            w_state_nxt = S_SHIFT;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_finish    = 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1      <= '0;
            r_a2      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_result  <= '0;
            r_iter    <= '0;
            r_mode    <= 1'b0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= w_finish;
            if (w_wr_a1)
                r_a1 <= WIDTH'(sdata_in);
            if (w_wr_a2)
                r_a2 <= WIDTH'(sdata_in);
            if (w_start) begin
                r_pending <= 1'b1;
                r_mode    <= sdata_in[1];
            end
            if (w_abort) begin
                // RESULT and ITER keep whatever the aborted run left behind.
                r_done <= 1'b0;
            end else if (clk_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_pending) begin
                            r_pending <= 1'b0;
                            r_done    <= 1'b0;
                            r_err     <= 1'b0;
                            r_iter    <= '0;
                            if (w_zero) begin
                                r_result <= r_a1 | r_a2;
                                r_err    <= (r_a1 == '0) && (r_a2 == '0);
                                r_done   <= 1'b1;
                            end else begin
                                r_a <= r_a1;
                                r_b <= r_a2;
                                r_k <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (r_a == r_b) begin
                            if (!r_mode) begin
                                r_result <= r_a;
                                r_done   <= 1'b1;
                            end
                        end else begin
                            r_iter <= sat_inc(r_iter);
                            if (!r_mode) begin
                                if (r_a > r_b)
                                    r_a <= r_a - r_b;
                                else
                                    r_b <= r_b - r_a;
                            end else if (!r_a[0] && !r_b[0]) begin
                                // Common factor of two, restored in SHIFT.
                                r_a <= r_a >> 1;
                                r_b <= r_b >> 1;
                                r_k <= r_k + 1'b1;
                            end else if (!r_a[0]) begin
                                r_a <= r_a >> 1;
                            end else if (!r_b[0]) begin
                                r_b <= r_b >> 1;
                            end else if (r_a > r_b) begin
                                r_a <= (r_a - r_b) >> 1;
                            end else begin
                                r_b <= (r_b - r_a) >> 1;
                            end
                        end
                    end
                    S_SHIFT: begin
                        r_result <= r_a << r_k;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        sdata_out = '0;
        if (srd) begin
            if (saddress == BASE)
                sdata_out = 32'(r_a1);
            else if (saddress == BASE + 16'h0004)
                sdata_out = 32'(r_a2);
            else if (saddress == BASE + 16'h000C)
                sdata_out = {29'd0, r_err, r_done, busy};
            else if (saddress == BASE + 16'h0010)
                sdata_out = 32'(r_result);
            else if (saddress == BASE + 16'h0014)
                sdata_out = 32'(r_iter);
        end
    end

endmodule

// File: tb/tb_gcd_coproc.sv
// tb_gcd_coproc: directed bench for gcd_coproc with hand-computed expectations.
module tb_gcd_coproc;
    localparam logic [15:0] A_A1  = 16'h0100;
    localparam logic [15:0] A_A2  = 16'h0104;
    localparam logic [15:0] A_CTL = 16'h0108;
    localparam logic [15:0] A_ST  = 16'h010C;
    localparam logic [15:0] A_RES = 16'h0110;
    localparam logic [15:0] A_IT  = 16'h0114;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic        done_irq;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int bcnt, icnt;

    gcd_coproc dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_in  (sdata_in),
        .sdata_out (sdata_out),
        .done_irq  (done_irq),
        .busy      (busy)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        saddress = a;
        sdata_in = d;
        swr      = 1'b1;
        @(negedge clk);
        swr      = 1'b0;
        saddress = '0;
        sdata_in = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        saddress = a;
        srd      = 1'b1;
        #1;
        d        = sdata_out;
        srd      = 1'b0;
        saddress = '0;
        check(tag, d, exp);
    endtask

    // Fixed-length observation window: counts cycles with busy and irq pulses.
    task automatic watch(input int n, output int nb, output int ni);
        nb = 0;
        ni = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy)     nb++;
            if (done_irq) ni++;
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(done_irq), 32'd0);
        chk_reg("rst_a1", A_A1, 32'd0);
        chk_reg("rst_status", A_ST, 32'd0);
        chk_reg("rst_result", A_RES, 32'd0);
        chk_reg("rst_iter", A_IT, 32'd0);
        reset = 1'b0;
        tick(1);

        // 1: subtractive 48,18 -> 6 after 4 steps, busy 5 cycles
        bus_wr(A_A1, 32'd48);
        bus_wr(A_A2, 32'd18);
        chk_reg("t1_a1_rd", A_A1, 32'd48);
        chk_reg("t1_ctrl_rd", A_CTL, 32'd0);
        bus_wr(A_CTL, 32'h1);
        check("t1_busy_pending", 32'(busy), 32'd0);
        watch(20, bcnt, icnt);
        check("t1_busy_cycles", 32'(bcnt), 32'd5);
        check("t1_irq_pulses", 32'(icnt), 32'd1);
        chk_reg("t1_result", A_RES, 32'd6);
        chk_reg("t1_iter", A_IT, 32'd4);
        chk_reg("t1_status", A_ST, 32'h2);

        // 2: binary 48,18 -> 6, 5 steps, k=1
        bus_wr(A_CTL, 32'h3);
        watch(20, bcnt, icnt);
        check("t2_busy_cycles", 32'(bcnt), 32'd7);
        check("t2_irq_pulses", 32'(icnt), 32'd1);
        chk_reg("t2_result", A_RES, 32'd6);
        chk_reg("t2_iter", A_IT, 32'd5);

        // 3: zero operand completes on the launch edge
        bus_wr(A_A1, 32'd0);
        bus_wr(A_A2, 32'd35);
        bus_wr(A_CTL, 32'h1);
        tick(1);
        check("t3_irq", 32'(done_irq), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        chk_reg("t3_result", A_RES, 32'd35);
        chk_reg("t3_status", A_ST, 32'h2);
        chk_reg("t3_iter", A_IT, 32'd0);
        tick(1);
        check("t3_irq_drop", 32'(done_irq), 32'd0);
        bus_wr(A_A2, 32'd0);
        bus_wr(A_CTL, 32'h1);
        tick(1);
        chk_reg("t3_zz_result", A_RES, 32'd0);
        chk_reg("t3_zz_status", A_ST, 32'h6);

        // 4: abort after 10 steps
        bus_wr(A_A1, 32'hFFFF_FFFF);
        bus_wr(A_A2, 32'd1);
        bus_wr(A_CTL, 32'h1);
        tick(11);
        check("t4_busy_run", 32'(busy), 32'd1);
        chk_reg("t4_iter_pre", A_IT, 32'd10);
        bus_wr(A_CTL, 32'h5);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_irq", 32'(done_irq), 32'd0);
        chk_reg("t4_status", A_ST, 32'h0);
        chk_reg("t4_iter", A_IT, 32'd10);
        chk_reg("t4_result", A_RES, 32'd0);
        watch(5, bcnt, icnt);
        check("t4_busy_after", 32'(bcnt), 32'd0);
        check("t4_irq_after", 32'(icnt), 32'd0);

        // 5: start held off by clk_en, then start while busy ignored
        clk_en = 1'b0;
        bus_wr(A_A1, 32'd48);
        bus_wr(A_A2, 32'd18);
        bus_wr(A_CTL, 32'h1);
        tick(20);
        check("t5_busy_held", 32'(busy), 32'd0);
        chk_reg("t5_status_held", A_ST, 32'h0);
        chk_reg("t5_a1_live", A_A1, 32'd48);
        clk_en = 1'b1;
        tick(1);
        check("t5_busy_launch", 32'(busy), 32'd1);
        bus_wr(A_A1, 32'd7);
        bus_wr(A_CTL, 32'h3);
        watch(20, bcnt, icnt);
        check("t5_irq_pulses", 32'(icnt), 32'd1);
        chk_reg("t5_result", A_RES, 32'd6);
        chk_reg("t5_iter", A_IT, 32'd4);
        chk_reg("t5_a1_new", A_A1, 32'd7);

        // 6: reset mid-run, then binary with large shift-back
        bus_wr(A_A1, 32'hFFFF_FFFF);
        bus_wr(A_A2, 32'd1);
        bus_wr(A_CTL, 32'h1);
        tick(5);
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_irq", 32'(done_irq), 32'd0);
        chk_reg("t6_a1", A_A1, 32'd0);
        chk_reg("t6_a2", A_A2, 32'd0);
        chk_reg("t6_result", A_RES, 32'd0);
        chk_reg("t6_iter", A_IT, 32'd0);
        chk_reg("t6_status", A_ST, 32'd0);
        tick(1);
        reset = 1'b0;
        watch(3, bcnt, icnt);
        check("t6_irq_after_rst", 32'(icnt), 32'd0);
        bus_wr(A_A1, 32'h8000_0000);
        bus_wr(A_A2, 32'h4000_0000);
        bus_wr(A_CTL, 32'h3);
        watch(60, bcnt, icnt);
        check("t6_irq_pulses", 32'(icnt), 32'd1);
        chk_reg("t6_bin_result", A_RES, 32'h4000_0000);
        chk_reg("t6_bin_iter", A_IT, 32'd31);
        chk_reg("t6_bin_status", A_ST, 32'h2);
        chk_reg("unmapped_rd", 16'h0200, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
